// File: rtl/multicycle_core_pkg.sv
// Shared types and encodings for the multicycle RV core.
// Holds FSM states, opcode constants and the instruction classifier.
package multicycle_core_pkg;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    WB,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    C_LUI,
    C_AUIPC,
    C_ADDI,
    C_ADD,
    C_JAL,
    C_JALR,
    C_EBREAK,
    C_ILLEGAL
  } instClass_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_JALR  = 3'b000;
  localparam logic [6:0] F7_ADD   = 7'b0000000;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;

  function automatic instClass_t decodeClass(input logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    unique case (1'b1)
      (op == OP_LUI):   decodeClass = C_LUI;
      (op == OP_AUIPC): decodeClass = C_AUIPC;
      (op == OP_IMM && f3 == F3_ADD):
        decodeClass = C_ADDI;
      (op == OP_REG && f3 == F3_ADD && f7 == F7_ADD):
        decodeClass = C_ADD;
      (op == OP_JAL):   decodeClass = C_JAL;
      (op == OP_JALR && f3 == F3_JALR):
        decodeClass = C_JALR;
      (w == EBREAK):    decodeClass = C_EBREAK;
      default:          decodeClass = C_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Instruction-memory request/response bundle.
// The core drives requests as master; memory answers as slave.
interface multicycle_core_if #(
    parameter int XLEN = 64
);
    import multicycle_core_pkg::*;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_inst;

    modport master(
        output imem_req_valid, imem_req_addr,
        input  imem_resp_valid, imem_resp_inst
    );

    modport slave(
        input  imem_req_valid, imem_req_addr,
        output imem_resp_valid, imem_resp_inst
    );
endinterface

// File: rtl/multicycle_core_regfile.sv
// Register file: two async read ports, one sync write port.
// x0 is never written and always reads zero.
module core_regfile
    import multicycle_core_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
endmodule

// File: rtl/multicycle_core.sv
// Three-cycle FETCH/EXEC/WB core for a small RV subset.
// Traps and EBREAK park the core in HALT until reset.
module multicycle_core
    import multicycle_core_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          NREGS    = 32
) (
    input  logic            clk,
    input  logic            rst,
    multicycle_core_if.master imem,
    output logic [XLEN-1:0] current_pc,
    output logic            retire,
    output logic            halted,
    output logic            illegal,
    output logic [XLEN-1:0] halt_code
);
    localparam int AW = $clog2(NREGS);
    localparam logic [XLEN-1:0] PC0 = RESET_PC[XLEN-1:0];

    state_t          state, stateNext;
    logic [XLEN-1:0] pc, resQ, npcQ;
    logic [31:0]     inst;
    logic            wenQ;

    instClass_t      cls;
    logic [XLEN-1:0] rs1Val, rs2Val;
    logic [XLEN-1:0] immI, immU, immJ;
    logic [XLEN-1:0] pcPlus4, jalrSum;
    logic [XLEN-1:0] res, npc;
    logic            wen, trap, brk;
    logic [AW-1:0]   raddr2;

    assign cls     = decodeClass(inst);
    assign immI    = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign immU    = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
    assign immJ    = {{(XLEN-20){inst[31]}}, inst[19:12],
                      inst[20], inst[30:21], 1'b0};
    assign pcPlus4 = pc + XLEN'(4);
    assign jalrSum = rs1Val + immI;

    // Port 2 doubles as the x10 tap for halt_code; only ADD needs rs2.
    assign raddr2 = (cls == C_ADD) ? inst[20 +: AW] : AW'(10);

    core_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (inst[15 +: AW]),
        .raddr2 (raddr2),
        .rdata1 (rs1Val),
        .rdata2 (rs2Val),
        .we     (state == WB && wenQ && !rst),
        .waddr  (inst[7 +: AW]),
        .wdata  (resQ)
    );

    always_comb begin
        res  = '0;
        npc  = pcPlus4;
        wen  = 1'b0;
        trap = 1'b0;
        brk  = 1'b0;
        unique case (cls)
            C_LUI:   begin res = immU;          wen = 1'b1; end
            C_AUIPC: begin res = pc + immU;     wen = 1'b1; end
            C_ADDI:  begin res = rs1Val + immI; wen = 1'b1; end
            C_ADD:   begin res = rs1Val + rs2Val; wen = 1'b1; end
            C_JAL: begin
                res  = pcPlus4;
                npc  = pc + immJ;
                wen  = 1'b1;
                trap = npc[1];
            end
            C_JALR: begin
                res  = pcPlus4;
                npc  = {jalrSum[XLEN-1:1], 1'b0};
                wen  = 1'b1;
                trap = npc[1];
            end
            C_EBREAK: brk = 1'b1;
            default:  trap = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            FETCH: if (imem.imem_resp_valid) stateNext = EXEC;
            EXEC:  stateNext = (trap || brk) ? HALT : WB;
            WB:    stateNext = FETCH;
            HALT:  stateNext = HALT;
            default: stateNext = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= PC0;
            inst      <= '0;
            resQ      <= '0;
            npcQ      <= '0;
            wenQ      <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            halt_code <= '0;
        end else begin
            unique case (state)
                FETCH: if (imem.imem_resp_valid) inst <= imem.imem_resp_inst;
                EXEC: begin
                    resQ <= res;
                    npcQ <= npc;
                    wenQ <= wen;
                    if (trap || brk) begin
                        halted    <= 1'b1;
                        illegal   <= trap;
                        halt_code <= rs2Val;
                    end
                end
                WB:      pc <= npcQ;
                default: ;
            endcase
        end
    end

    assign imem.imem_req_valid = (state == FETCH);
    assign imem.imem_req_addr  = pc;
    assign current_pc          = pc;
    assign retire              = (state == WB) && !rst;
endmodule
